// File: rtl/adjacency_responder.sv
// Responder side of the node-fetch interface. Holds a CSR graph (offset
// table + edge table), emits the special-node header at run start, then
// streams neighbour indices for each requested node with a countdown tag.
module adjacency_responder #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_COUNTER_WIDTH   = 5,
    parameter int PARAM_NODE_COUNT      = 1024,
    parameter int PARAM_EDGE_DEPTH      = 4096,
    parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [1:0]                       ld_sel,
    input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] ld_addr,
    input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] ld_data,
    input  logic                             start_run,
    input  logic                             part_sel,
    output logic                             hdr_valid,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx,
    output logic                             rsp_valid,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
    output logic                             rsp_last,
    output logic                             rsp_err
);

    localparam int NW     = PARAM_NODE_IDX_WIDTH;
    localparam int CW     = PARAM_COUNTER_WIDTH;
    localparam int EAW    = PARAM_EDGE_ADDR_WIDTH;
    localparam int OFS_AW = $clog2(PARAM_NODE_COUNT + 1);
    localparam int MAX_DEG = (1 << CW) - 1;
    localparam logic [CW-1:0]  CNT_ONE = 1;
    localparam logic [CW-1:0]  CNT_TWO = 2;
    localparam logic [EAW-1:0] EA_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WAIT, S_OFS_LO, S_OFS_HI, S_STREAM
    } state_t;

    state_t          r_state;
    logic            r_ld_ready, r_hdr_valid, r_req_ready, r_rsp_valid;
    logic [NW-1:0]   r_next_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_last, r_err;
    logic            r_part;
    logic [1:0]      r_hdr_step;
    logic [NW-1:0]   r_hdr [4];
    logic [NW-1:0]   r_node;
    logic            r_oor;
    logic [EAW-1:0]  r_ofs_lo, r_ofs_q, r_edge_addr;

    logic [EAW-1:0]  r_ofs_mem  [PARAM_NODE_COUNT + 1];
    logic [NW-1:0]   r_edge_mem [PARAM_EDGE_DEPTH];

    logic            w_ld_en, w_req_fire, w_req_oor;
    logic            w_ofs_wr, w_ofs_rd, w_edge_wr, w_hdr_wr;
    logic [31:0]     w_ofs_addr32;
    logic [OFS_AW-1:0] w_ofs_addr;
    logic [EAW-1:0]  w_deg;
    logic            w_deg_ovf;
    logic [1:0]      w_hdr_next;

    assign w_ld_en    = ld_valid && r_ld_ready;
    assign w_req_fire = req_valid && r_req_ready;
    assign w_req_oor  = 32'(node_idx) >= 32'(PARAM_NODE_COUNT);
    assign w_ofs_wr   = w_ld_en && (ld_sel == 2'd0) && (32'(ld_addr) <= 32'(PARAM_NODE_COUNT));
    assign w_edge_wr  = w_ld_en && (ld_sel == 2'd1) && (32'(ld_addr) < 32'(PARAM_EDGE_DEPTH));
    assign w_hdr_wr   = w_ld_en && (ld_sel == 2'd2) && (32'(ld_addr) < 32'd4);
    // Offset reads: n is presented in the accept cycle, n+1 one cycle later,
    // so both words are on hand when the degree is formed.
    assign w_ofs_rd   = (r_state == S_WAIT && w_req_fire && !w_req_oor) ||
                        (r_state == S_OFS_LO && !r_oor);
    assign w_ofs_addr32 = w_ofs_wr ? 32'(ld_addr) :
                          (r_state == S_OFS_LO) ? 32'(r_node) + 32'd1 : 32'(node_idx);
    assign w_ofs_addr = w_ofs_addr32[OFS_AW-1:0];
    assign w_deg      = r_ofs_q - r_ofs_lo;
    assign w_deg_ovf  = 32'(w_deg) > 32'(MAX_DEG);
    assign w_hdr_next = (r_hdr_step == 2'd0 && !r_part) ? 2'd3 : r_hdr_step + 2'd1;

    // Single-port offset table: loader writes in IDLE, engine reads otherwise.
    always_ff @(posedge clk) begin
        if (w_ofs_wr) r_ofs_mem[w_ofs_addr] <= ld_data;
        else if (w_ofs_rd) r_ofs_q <= r_ofs_mem[w_ofs_addr];
    end

    // Edge table write port; its read port feeds the response register below.
    always_ff @(posedge clk) begin
        if (w_edge_wr) r_edge_mem[ld_addr] <= ld_data[NW-1:0];
    end

    // Main FSM with registered outputs and header register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ld_ready  <= 1'b1;
            r_hdr_valid <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_next_idx  <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_part      <= 1'b0;
            r_hdr_step  <= 2'd0;
            r_oor       <= 1'b0;
            for (int i = 0; i < 4; i++) r_hdr[i] <= '0;
        end else begin
            if (w_hdr_wr) r_hdr[ld_addr[1:0]] <= ld_data[NW-1:0];
            if (!start_run) begin
                r_state     <= S_IDLE;
                r_ld_ready  <= 1'b1;
                r_hdr_valid <= 1'b0;
                r_req_ready <= 1'b0;
                r_rsp_valid <= 1'b0;
                r_next_idx  <= '0;
                r_cnt       <= '0;
                r_last      <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_part      <= part_sel;
                        r_hdr_step  <= 2'd0;
                        r_hdr_valid <= 1'b1;
                        r_next_idx  <= r_hdr[0];
                        r_ld_ready  <= 1'b0;
                        r_state     <= S_HDR;
                    end
                    S_HDR: begin
                        if (r_hdr_step == 2'd3) begin
                            r_hdr_valid <= 1'b0;
                            r_next_idx  <= '0;
                            r_req_ready <= 1'b1;
                            r_state     <= S_WAIT;
                        end else begin
                            r_hdr_step <= w_hdr_next;
                            r_next_idx <= r_hdr[w_hdr_next];
                        end
                    end
                    S_WAIT: begin
                        if (w_req_fire) begin
                            r_node      <= node_idx;
                            r_oor       <= w_req_oor;
                            r_req_ready <= 1'b0;
                            r_state     <= S_OFS_LO;
                        end
                    end
                    S_OFS_LO: begin
                        r_ofs_lo <= r_ofs_q;
                        r_state  <= S_OFS_HI;
                    end
                    S_OFS_HI: begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_STREAM;
                        // Error and empty cases collapse to a single tag-only beat.
                        if (r_oor || w_deg == '0 || w_deg_ovf) begin
                            r_next_idx <= '0;
                            r_cnt      <= '0;
                            r_last     <= 1'b1;
                            r_err      <= r_oor || w_deg_ovf;
                        end else begin
                            r_next_idx  <= r_edge_mem[r_ofs_lo];
                            r_cnt       <= w_deg[CW-1:0];
                            r_last      <= (w_deg[CW-1:0] == CNT_ONE);
                            r_err       <= 1'b0;
                            r_edge_addr <= r_ofs_lo + EA_ONE;
                        end
                    end
                    S_STREAM: begin
                        if (r_last) begin
                            r_rsp_valid <= 1'b0;
                            r_next_idx  <= '0;
                            r_cnt       <= '0;
                            r_last      <= 1'b0;
                            r_err       <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_state     <= S_WAIT;
                        end else begin
                            r_next_idx  <= r_edge_mem[r_edge_addr];
                            r_edge_addr <= r_edge_addr + EA_ONE;
                            r_cnt       <= r_cnt - CNT_ONE;
                            r_last      <= (r_cnt == CNT_TWO);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ld_ready          = r_ld_ready;
    assign hdr_valid         = r_hdr_valid;
    assign req_ready         = r_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign next_node_idx     = r_next_idx;
    assign next_node_counter = r_cnt;
    assign rsp_last          = r_last;
    assign rsp_err           = r_err;

endmodule
